// File: rtl/i2c_write_engine.sv
// i2c_write_engine: byte-level I2C master write engine for the camera
// register-configuration sequencer. Sends a 24-bit word (device address and
// two data bytes) as START, 3x(8 data + ACK slot), STOP. Each bit is four
// quarter-bit ticks of CLK_DIV clk_25M cycles.
// Optional feature macro: I2C_NACK_ABORT_EN. When it is defined, a NACK after
// byte 1 or byte 2 skips the remaining bytes and goes straight to STOP.
module i2c_write_engine #(
  parameter int CLK_DIV = 312
) (
  input  logic        clk_25M,
  input  logic        camera_rst,
  input  logic [23:0] i2c_data,
  input  logic        start,
  output logic        tr_end,
  output logic        ack,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACKB, STOP, DONE} state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [1:0]  q, q_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [23:0] shreg;
  logic        nack;
  logic        sda_oe;
  logic        scl_n, sda_oe_n;
  logic        tick;
  logic        sda_in;
  logic        abort;

  // Quarter-bit tick: last cycle of every CLK_DIV-cycle window outside IDLE
  assign tick = (state != IDLE) && (cnt == DIV_M1);

  // Open-drain SDA: pull low or release, never drive high
  assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;
  assign sda_in   = i2c_sdat;

`ifdef I2C_NACK_ABORT_EN
  assign abort = nack;
`else
  assign abort = 1'b0;
`endif

  // Next state, quarter index and bit counter; everything moves on ticks
  always_comb begin
    state_n   = state;
    q_n       = q;
    bit_cnt_n = bit_cnt;
    case (state)
      IDLE: begin
        if (start && !tr_end) begin
          state_n = START;
          q_n     = 2'd0;
        end
      end
      START: begin
        if (tick) begin
          q_n = q + 2'd1;
          if (q == 2'd3) begin
            state_n   = BIT;
            bit_cnt_n = 5'd0;
          end
        end
      end
      BIT: begin
        if (tick) begin
          q_n = q + 2'd1;
          if (q == 2'd3) begin
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt[2:0] == 3'd7) state_n = ACKB;
          end
        end
      end
      ACKB: begin
        if (tick) begin
          q_n = q + 2'd1;
          // bit_cnt is 24 once all three bytes have been shifted out
          if (q == 2'd3) state_n = (bit_cnt == 5'd24 || abort) ? STOP : BIT;
        end
      end
      STOP: begin
        if (tick) begin
          q_n = q + 2'd1;
          if (q == 2'd3) state_n = DONE;
        end
      end
      DONE: begin
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Line levels for the upcoming state/quarter, so outputs can be registered
  always_comb begin
    scl_n    = 1'b1;
    sda_oe_n = 1'b0;
    case (state_n)
      START: sda_oe_n = q_n[1];
      BIT: begin
        scl_n    = (q_n == 2'd1) || (q_n == 2'd2);
        // bit_cnt_n only changes entering q0, so SDA only moves at q0
        sda_oe_n = ~shreg[5'd23 - bit_cnt_n];
      end
      ACKB: scl_n = (q_n == 2'd1) || (q_n == 2'd2);
      STOP: begin
        scl_n    = (q_n != 2'd0);
        sda_oe_n = (q_n != 2'd3);
      end
      default: begin
        scl_n    = 1'b1;
        sda_oe_n = 1'b0;
      end
    endcase
  end

  // FSM state, tick counter, latched word, NACK tracking and registered outputs
  always_ff @(posedge clk_25M or posedge camera_rst) begin
    if (camera_rst) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      q        <= 2'd0;
      bit_cnt  <= 5'd0;
      shreg    <= 24'd0;
      nack     <= 1'b0;
      ack      <= 1'b0;
      tr_end   <= 1'b0;
      i2c_sclk <= 1'b1;
      sda_oe   <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      bit_cnt  <= bit_cnt_n;
      i2c_sclk <= scl_n;
      sda_oe   <= sda_oe_n;
      tr_end   <= (state_n == DONE);
      // Held at zero in IDLE (and on the way back), so START begins a fresh window
      if (state == IDLE || state_n == IDLE || tick) cnt <= 16'd0;
      else                                          cnt <= cnt + 16'd1;
      if (state == IDLE && state_n == START) begin
        shreg <= i2c_data;
        nack  <= 1'b0;
      end else if (state == ACKB && tick && q == 2'd2 && sda_in) begin
        nack <= 1'b1;
      end
      if (state_n == DONE && state != DONE) ack <= nack;
    end
  end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Randomised self-checking bench for i2c_write_engine. A bus monitor decodes
// SCL/SDA into START/bits/STOP and plays an ACK/NACK slave; a byte-level
// reference model predicts the bit stream, ack and transaction length.
module tb_i2c_write_engine;
  localparam int DIV = 6;
`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        clk_25M = 1'b0;
  logic        camera_rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] i2c_data = 24'd0;
  logic        tr_end, ack, i2c_sclk;
  wire         i2c_sdat;
  logic        sl_low = 1'b0;
  logic [2:0]  sl_mask = 3'd0;

  assign i2c_sdat = sl_low ? 1'b0 : 1'bz;
  pullup (i2c_sdat);

  i2c_write_engine #(.CLK_DIV(DIV)) dut (
    .clk_25M(clk_25M), .camera_rst(camera_rst), .i2c_data(i2c_data),
    .start(start), .tr_end(tr_end), .ack(ack), .i2c_sclk(i2c_sclk),
    .i2c_sdat(i2c_sdat)
  );

  always #20 clk_25M = ~clk_25M;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and slave
  int          cyc = 0, nb = 0, stop_cnt = 0, start_cnt = 0, hi_chg = 0, scl_bad = 0;
  int          t_rise = 0;
  logic [31:0] bits = 32'd0;
  logic        p_scl = 1'b1, p_sda = 1'b1, had_rise = 1'b0, prv_ok = 1'b0;

  always @(negedge clk_25M) begin
    cyc++;
    if (p_scl && i2c_sclk && p_sda && !i2c_sdat) begin
      start_cnt++; nb = 0; bits = 32'd0; hi_chg = 1; stop_cnt = 0;
      scl_bad = 0; had_rise = 1'b0; prv_ok = 1'b0; sl_low = 1'b0;
    end else if (p_scl && i2c_sclk && !p_sda && i2c_sdat) begin
      stop_cnt++; hi_chg++;
    end else if (p_scl && i2c_sclk && (p_sda != i2c_sdat)) begin
      hi_chg++;
    end
    if (!p_scl && i2c_sclk) begin
      if (prv_ok && (cyc - t_rise) != 4*DIV) scl_bad++;
      t_rise = cyc; prv_ok = 1'b1; had_rise = 1'b1;
    end
    if (p_scl && !i2c_sclk && had_rise) begin
      if ((cyc - t_rise) != 2*DIV) scl_bad++;
      had_rise = 1'b0;
      bits = {bits[30:0], p_sda};
      nb++;
      if      (nb == 8)  sl_low = !sl_mask[0];
      else if (nb == 17) sl_low = !sl_mask[1];
      else if (nb == 26) sl_low = !sl_mask[2];
      else if (nb == 9 || nb == 18 || nb == 27) sl_low = 1'b0;
    end
    p_scl = i2c_sclk;
    p_sda = i2c_sdat;
  end

  // Byte-level reference: expected line bits (data MSB first, then ACK slot)
  function automatic void model(input logic [23:0] d, input logic [2:0] m,
                                output logic [31:0] eb, output int ns, output logic ea);
    logic [7:0] by;
    eb = 32'd0; ns = 0; ea = |m;
    for (int b = 0; b < 3; b++) begin
      by = (b == 0) ? d[23:16] : (b == 1) ? d[15:8] : d[7:0];
      for (int i = 7; i >= 0; i--) begin
        eb = {eb[30:0], by[i]}; ns++;
      end
      eb = {eb[30:0], m[b]}; ns++;
      if (ABORT && m[b]) break;
    end
  endfunction

  task automatic run_txn(input string tag, input logic [23:0] d, input logic [2:0] m,
                         input bit pulse, input bit rel_rst);
    logic [31:0] eb;
    int          ns, n, ticks;
    logic        ea, got, prev_ack;
    model(d, m, eb, ns, ea);
    ticks    = 4 + ns*4 + 4;
    prev_ack = exp_ack;
    @(negedge clk_25M);
    sl_mask = m; i2c_data = d; start = 1'b1;
    if (rel_rst) camera_rst = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 130*DIV + 20) begin
      @(posedge clk_25M); n++;
      @(negedge clk_25M);
      if (n == 1) begin
        i2c_data = 24'($urandom);
        if (pulse) start = 1'b0;
      end
      if (n == 10) chk({tag, "_ack_hold"}, ack, prev_ack);
      if (tr_end) got = 1'b1;
    end
    chk({tag, "_done"},    got, 1);
    chk({tag, "_latency"}, n, 1 + ticks*DIV);
    chk({tag, "_ack"},     ack, ea);
    chk({tag, "_nbits"},   nb, ns);
    chk({tag, "_bits"},    bits, eb);
    chk({tag, "_stop"},    stop_cnt, 1);
    chk({tag, "_sda_hi"},  hi_chg, 2);
    chk({tag, "_scl_tim"}, scl_bad, 0);
    exp_ack = ea;
    if (pulse) begin
      @(negedge clk_25M);
      chk({tag, "_pulse_1cyc"}, tr_end, 0);
    end
  endtask

  task automatic drop_start(input string tag);
    @(negedge clk_25M);
    start = 1'b0;
    chk({tag, "_trend_hold"}, tr_end, 1);
    @(negedge clk_25M);
    chk({tag, "_trend_fall"}, tr_end, 0);
  endtask

  initial begin
    int          s0, bad, w;
    logic [23:0] d;
    logic [2:0]  m;
    bit          p;

    repeat (3) @(negedge clk_25M);
    chk("rst_tr_end", tr_end, 0);
    chk("rst_ack", ack, 0);
    chk("rst_scl", i2c_sclk, 1);
    chk("rst_sda", i2c_sdat, 1);
    camera_rst = 1'b0;
    repeat (4) @(negedge clk_25M);
    chk("idle_scl", i2c_sclk, 1);
    chk("idle_start_cnt", start_cnt, 0);

    run_txn("basic", 24'h90_08B1, 3'b000, 1'b0, 1'b0);
    drop_start("basic");

    run_txn("nack2", 24'h90_08B1, 3'b010, 1'b0, 1'b0);
    s0 = start_cnt; bad = 0;
    repeat (5000) begin
      @(negedge clk_25M);
      if (!tr_end) bad++;
    end
    chk("hold_trend", bad, 0);
    chk("hold_no_restart", start_cnt, s0);
    drop_start("nack2");

    run_txn("ffff", 24'h90_FFFF, 3'b000, 1'b0, 1'b0);
    drop_start("ffff");

    run_txn("pulse", 24'($urandom), 3'b001, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      d = 24'($urandom);
      m = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      p = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", k), d, m, p, 1'b0);
      if (!p) drop_start($sformatf("rnd%0d", k));
    end

    // Reset during bit 10 of a transfer, with ack currently 1
    run_txn("pre_rst", 24'($urandom), 3'b100, 1'b1, 1'b0);
    @(negedge clk_25M);
    sl_mask = 3'b000; i2c_data = 24'($urandom); start = 1'b1;
    s0 = start_cnt; w = 0;
    while (!(start_cnt > s0 && nb >= 10) && w < 60*DIV) begin
      @(negedge clk_25M); w++;
    end
    chk("rst_reach_bit10", (start_cnt > s0 && nb >= 10), 1);
    #2 camera_rst = 1'b1;
    #1;
    chk("midrst_scl", i2c_sclk, 1);
    chk("midrst_sda", i2c_sdat, 1);
    chk("midrst_tr_end", tr_end, 0);
    chk("midrst_ack", ack, 0);
    exp_ack = 1'b0;
    repeat (5) @(negedge clk_25M);
    run_txn("after_rst", 24'($urandom), 3'b000, 1'b0, 1'b1);
    drop_start("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
